// File: rtl/alu_exec_unit.sv
// Handshaked ALU: single-cycle add/sub/logic/cmp, WIDTH-cycle iterative mul/div, registered flags and accumulator.
// Latency 1 cycle (WIDTH+1 for mul and nonzero div); in_ready only in IDLE, result held in DONE until out_ready.
module alu_exec_unit #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] ACC_RST = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic             use_acc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry,
    output logic             zero,
    output logic             div_zero,
    output logic [WIDTH-1:0] acc_q
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_DIV = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    localparam int               CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q;
    logic [WIDTH-1:0] hi_q, lo_q, b_q;
    logic [CW-1:0]    cnt_q;
    logic             is_div_q;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH:0]   add_s, sub_d;
    logic [WIDTH-1:0] s_res, s_hi;
    logic             s_c, s_dz, iterative;

    assign in_ready  = (state_q == S_IDLE);
    assign op_a      = use_acc ? acc_q : a;
    assign add_s     = {1'b0, op_a} + {1'b0, b};
    assign sub_d     = {1'b0, op_a} - {1'b0, b};
    assign iterative = (opcode == OP_MUL) || ((opcode == OP_DIV) && (b != '0));

    always_comb begin
        s_res = '0;
        s_hi  = '0;
        s_c   = 1'b0;
        s_dz  = 1'b0;
        case (opcode)
            OP_ADD: begin s_res = add_s[WIDTH-1:0]; s_c = add_s[WIDTH]; end
            OP_SUB: begin s_res = sub_d[WIDTH-1:0]; s_c = sub_d[WIDTH]; end
            OP_AND: s_res = op_a & b;
            OP_OR:  s_res = op_a | b;
            OP_XOR: s_res = op_a ^ b;
            OP_CMP: begin s_res = (op_a == b) ? WIDTH'(1) : '0; s_c = sub_d[WIDTH]; end
            OP_DIV: begin s_hi = op_a; s_c = 1'b1; s_dz = 1'b1; end
            default: ;
        endcase
    end

    // One shift-add (mul) or restoring-subtract (div) step over the {hi,lo} pair.
    logic [WIDTH:0]   mul_sum, div_t;
    logic             div_ge;
    logic [WIDTH-1:0] div_r, it_hi, it_lo;

    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign div_t   = {hi_q, lo_q[WIDTH-1]};
    assign div_ge  = (div_t >= {1'b0, b_q});
    assign div_r   = div_ge ? WIDTH'(div_t - {1'b0, b_q}) : div_t[WIDTH-1:0];
    assign it_hi   = is_div_q ? div_r : mul_sum[WIDTH:1];
    assign it_lo   = is_div_q ? {lo_q[WIDTH-2:0], div_ge} : {mul_sum[0], lo_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            div_zero  <= 1'b0;
            acc_q     <= ACC_RST;
            hi_q      <= '0;
            lo_q      <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        if (iterative) begin
                            hi_q     <= '0;
                            lo_q     <= op_a;
                            b_q      <= b;
                            is_div_q <= (opcode == OP_DIV);
                            cnt_q    <= '0;
                            state_q  <= S_CALC;
                        end else begin
                            result    <= s_res;
                            result_hi <= s_hi;
                            carry     <= s_c;
                            zero      <= (s_res == '0);
                            div_zero  <= s_dz;
                            out_valid <= 1'b1;
                            state_q   <= S_DONE;
                        end
                    end
                end
                S_CALC: begin
                    hi_q  <= it_hi;
                    lo_q  <= it_lo;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        result    <= it_lo;
                        result_hi <= it_hi;
                        carry     <= is_div_q ? 1'b0 : (|it_hi);
                        zero      <= (it_lo == '0);
                        div_zero  <= 1'b0;
                        out_valid <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        acc_q     <= result;
                        out_valid <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
